uart_reg_ctrl: RTL and testbench

//   Command controller between uart_rx and uart_tx. Parses fixed 4-byte frames from the

---
 rtl/uart_reg_ctrl_if.sv | 24 ++
 rtl/uart_reg_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_reg_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_ctrl_if.sv
// rtl/uart_reg_ctrl_if.sv - uart_rx/uart_tx byte handshake bundle for uart_reg_ctrl
interface uart_reg_ctrl_if;
  logic [7:0] i_rx_data;
  logic       i_rx_vld;
  logic       i_tx_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_vld;

  modport slave (
    input  i_rx_data,
    input  i_rx_vld,
    input  i_tx_busy,
    output o_tx_data,
    output o_tx_vld
  );

  modport master (
    output i_rx_data,
    output i_rx_vld,
    output i_tx_busy,
    input  o_tx_data,
    input  o_tx_vld
  );
endinterface

// File: rtl/uart_reg_ctrl.sv
// rtl/uart_reg_ctrl.sv - 4-byte UART command frame parser driving a 4 x 8-bit register bank
module uart_reg_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50_000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15,
  parameter logic [7:0]  REG2_INIT   = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_reg_ctrl_if.slave   bus,
  output logic [7:0]       o_disp_data,
  output logic [7:0]       o_led,
  output logic [7:0]       o_ctrl,
  output logic [7:0]       o_err_cnt,
  output logic             o_busy
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CMD,
    S_GET_DATA,
    S_GET_CHK,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_cmd;
  logic [7:0]       r_data;
  logic [7:0]       r_chk;
  logic [7:0]       r_resp;
  logic [7:0]       r_tx_last;
  logic [7:0]       r_err_cnt;
  logic [7:0]       r_regs [4];
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_frame;
  logic             w_timeout;
  logic             w_chk_ok;
  logic             w_is_read;
  logic [1:0]       w_addr;
  logic             w_tx_strobe;
  logic             w_err_inc;

  assign w_in_frame  = (r_state == S_GET_CMD) || (r_state == S_GET_DATA) ||
                       (r_state == S_GET_CHK);
  // A byte landing in the expiry cycle is still accepted.
  assign w_timeout   = w_in_frame && !bus.i_rx_vld && (r_cnt == CNT_LAST);
  assign w_chk_ok    = ((r_cmd ^ r_data) == r_chk);
  assign w_is_read   = r_cmd[7];
  assign w_addr      = r_cmd[1:0];
  assign w_tx_strobe = (r_state == S_RESP) && !bus.i_tx_busy;
  assign w_err_inc   = ((r_state == S_EXEC) && !w_chk_ok) || w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_rx_vld && (bus.i_rx_data == SYNC_BYTE)) begin
          w_state_nxt = S_GET_CMD;
        end
      end
      S_GET_CMD: begin
        if (bus.i_rx_vld) begin
          w_state_nxt = S_GET_DATA;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (bus.i_rx_vld) begin
          w_state_nxt = S_GET_CHK;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GET_CHK: begin
        if (bus.i_rx_vld) begin
          w_state_nxt = S_EXEC;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (!bus.i_tx_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // o_tx_data shows the pending response only during its strobe, otherwise the last one sent.
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    bus.o_tx_vld  = w_tx_strobe;
    bus.o_tx_data = w_tx_strobe ? r_resp : r_tx_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_in_frame && !bus.i_rx_vld) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd  <= '0;
      r_data <= '0;
      r_chk  <= '0;
    end else if (bus.i_rx_vld) begin
      case (r_state)
        S_GET_CMD:  r_cmd  <= bus.i_rx_data;
        S_GET_DATA: r_data <= bus.i_rx_data;
        S_GET_CHK:  r_chk  <= bus.i_rx_data;
        default: ;
      endcase
    end
  end

  // Read responses sample the bank in EXEC, before any write of the same frame could land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs[0] <= 8'h00;
      r_regs[1] <= 8'h00;
      r_regs[2] <= REG2_INIT;
      r_regs[3] <= 8'h00;
      r_resp    <= 8'h00;
    end else if (r_state == S_EXEC) begin
      if (!w_chk_ok) begin
        r_resp <= NAK_BYTE;
      end else if (w_is_read) begin
        r_resp <= r_regs[w_addr];
      end else begin
        r_regs[w_addr] <= r_data;
        r_resp         <= ACK_BYTE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_last <= 8'h00;
    end else if (w_tx_strobe) begin
      r_tx_last <= r_resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_inc && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_disp_data = r_regs[0];
  assign o_led       = r_regs[1];
  assign o_ctrl      = r_regs[2];
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// tb/tb_uart_reg_ctrl.sv - self-checking bench for uart_reg_ctrl
module tb_uart_reg_ctrl;

  localparam int TO_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] o_disp_data;
  logic [7:0] o_led;
  logic [7:0] o_ctrl;
  logic [7:0] o_err_cnt;
  logic       o_busy;

  uart_reg_ctrl_if bus ();

  uart_reg_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_disp_data (o_disp_data),
    .o_led       (o_led),
    .o_ctrl      (o_ctrl),
    .o_err_cnt   (o_err_cnt),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] chk;
    logic [7:0] resp;
    logic [7:0] disp;
    logic [7:0] led;
    logic [7:0] ctrl;
    logic [7:0] err;
  } vec_t;

  vec_t       vecs [11];
  logic [7:0] exp_q [$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         tx_cnt = 0;
  int         exp_tx_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] exp_err = 8'h00;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (bus.o_tx_vld === 1'b1) tx_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] disp, input logic [7:0] led,
                            input logic [7:0] ctrl, input logic [7:0] err, input logic busy);
    check({name, " disp"}, o_disp_data, disp);
    check({name, " led"},  o_led, led);
    check({name, " ctrl"}, o_ctrl, ctrl);
    check({name, " err"},  o_err_cnt, err);
    check({name, " busy"}, {7'd0, o_busy}, {7'd0, busy});
  endtask

  // Called at posedge+1; returns at posedge+1 after one idle gap cycle.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_vld  = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_vld  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data, input logic [7:0] chk);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(data);
    send_byte(chk);
  endtask

  task automatic wait_resp(input string name);
    logic [7:0] exp;
    bit seen;
    seen = 1'b0;
    exp  = exp_q.pop_front();
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.o_tx_vld === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s resp: got no strobe required %02h", name, exp);
    end else begin
      check({name, " resp"}, bus.o_tx_data, exp);
      last_tx = exp;
      @(posedge clk); #1;
    end
  endtask

  task automatic frame_expect(input string name, input logic [7:0] cmd, input logic [7:0] data,
                              input logic [7:0] chk, input logic [7:0] resp);
    exp_q.push_back(resp);
    exp_tx_cnt++;
    send_frame(cmd, data, chk);
    wait_resp(name);
  endtask

  initial begin
    bus.i_rx_data = 8'h00;
    bus.i_rx_vld  = 1'b0;
    bus.i_tx_busy = 1'b0;

    //            cmd    data   chk    resp   disp   led    ctrl   err
    vecs[0]  = '{8'h01, 8'h3C, 8'h3D, 8'h06, 8'h00, 8'h3C, 8'h01, 8'h00};
    vecs[1]  = '{8'h81, 8'h00, 8'h81, 8'h3C, 8'h00, 8'h3C, 8'h01, 8'h00};
    vecs[2]  = '{8'h02, 8'hF0, 8'h00, 8'h15, 8'h00, 8'h3C, 8'h01, 8'h01};
    vecs[3]  = '{8'h00, 8'h5A, 8'h5A, 8'h06, 8'h5A, 8'h3C, 8'h01, 8'h01};
    vecs[4]  = '{8'h02, 8'h00, 8'h02, 8'h06, 8'h5A, 8'h3C, 8'h00, 8'h01};
    vecs[5]  = '{8'h82, 8'h77, 8'hF5, 8'h00, 8'h5A, 8'h3C, 8'h00, 8'h01};
    vecs[6]  = '{8'h7C, 8'h11, 8'h6D, 8'h06, 8'h11, 8'h3C, 8'h00, 8'h01};
    vecs[7]  = '{8'h80, 8'h00, 8'h80, 8'h11, 8'h11, 8'h3C, 8'h00, 8'h01};
    vecs[8]  = '{8'h81, 8'h00, 8'h00, 8'h15, 8'h11, 8'h3C, 8'h00, 8'h02};
    vecs[9]  = '{8'h03, 8'h99, 8'h9A, 8'h06, 8'h11, 8'h3C, 8'h00, 8'h02};
    vecs[10] = '{8'h83, 8'h00, 8'h83, 8'h99, 8'h11, 8'h3C, 8'h00, 8'h02};

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
    check("reset tx_vld",  {7'd0, bus.o_tx_vld}, 8'h00);
    check("reset tx_data", bus.o_tx_data, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      frame_expect($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].data, vecs[i].chk, vecs[i].resp);
      check_outs($sformatf("vec%0d", i), vecs[i].disp, vecs[i].led, vecs[i].ctrl, vecs[i].err, 1'b0);
    end
    exp_err = 8'h02;

    // Write latency: CHK in cycle N, EXEC in N+1, register and strobe visible in N+2.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hE7);
    bus.i_rx_data = 8'hE7;
    bus.i_rx_vld  = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_vld  = 1'b0;
    check("lat exec disp", o_disp_data, 8'h11);
    check("lat exec vld", {7'd0, bus.o_tx_vld}, 8'h00);
    @(posedge clk); #1;
    check("lat n+2 disp", o_disp_data, 8'hE7);
    check("lat n+2 vld", {7'd0, bus.o_tx_vld}, 8'h01);
    check("lat n+2 data", bus.o_tx_data, 8'h06);
    exp_tx_cnt++;
    last_tx = 8'h06;
    @(posedge clk); #1;
    check("lat after vld", {7'd0, bus.o_tx_vld}, 8'h00);
    check("lat hold data", bus.o_tx_data, 8'h06);

    // Timeout: expiry exactly TO_CYC cycles after the last accepted byte.
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYC - 2) @(posedge clk);
    #1;
    check("to last cycle busy", {7'd0, o_busy}, 8'h01);
    @(posedge clk); #1;
    exp_err = exp_err + 8'd1;
    check_outs("to expired", 8'hE7, 8'h3C, 8'h00, exp_err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("to no tx", tx_cnt[7:0], exp_tx_cnt[7:0]);

    // A byte in the expiry cycle wins over the timeout.
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (TO_CYC - 2) @(posedge clk);
    #1;
    exp_q.push_back(8'h06);
    exp_tx_cnt++;
    send_byte(8'h55);
    send_byte(8'h56);
    wait_resp("byte wins");
    check("byte wins err", o_err_cnt, exp_err);
    frame_expect("reg3 read", 8'h83, 8'h00, 8'h83, 8'h55);

    // tx busy held around a good write; junk in IDLE ignored.
    bus.i_tx_busy = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("junk busy", {7'd0, o_busy}, 8'h00);
    exp_q.push_back(8'h06);
    exp_tx_cnt++;
    send_frame(8'h01, 8'hC3, 8'hC2);
    repeat (184) @(posedge clk);
    #1;
    check("busy no tx", tx_cnt[7:0], 8'(exp_tx_cnt - 1));
    check("busy held", {7'd0, o_busy}, 8'h01);
    check("busy hold data", bus.o_tx_data, last_tx);
    check("busy led", o_led, 8'hC3);
    bus.i_tx_busy = 1'b0;
    @(negedge clk);
    exp_b = exp_q.pop_front();
    check("busy fall vld", {7'd0, bus.o_tx_vld}, 8'h01);
    check("busy fall data", bus.o_tx_data, exp_b);
    last_tx = exp_b;
    @(negedge clk);
    check("busy one strobe", {7'd0, bus.o_tx_vld}, 8'h00);
    @(posedge clk); #1;
    check("busy tx count", tx_cnt[7:0], exp_tx_cnt[7:0]);

    // Asynchronous reset mid-frame.
    send_byte(8'hA5);
    send_byte(8'h01);
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("mid rst", 8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
    check("mid rst tx_vld",  {7'd0, bus.o_tx_vld}, 8'h00);
    check("mid rst tx_data", bus.o_tx_data, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame_expect("post rst read", 8'h81, 8'h00, 8'h81, 8'h00);
    exp_err = 8'h00;

    // Error counter saturation.
    for (int i = 0; i < 256; i++) begin
      frame_expect($sformatf("sat%0d", i), 8'h01, 8'h00, 8'h00, 8'h15);
      if (i == 254) check("sat 255", o_err_cnt, 8'hFF);
    end
    check("sat no wrap", o_err_cnt, 8'hFF);
    check("sat led kept", o_led, 8'h00);
    check("final tx count lo", tx_cnt[7:0], exp_tx_cnt[7:0]);
    check("final tx count hi", tx_cnt[15:8], exp_tx_cnt[15:8]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
